// File: rtl/ahb_slave_interface_if.sv
// AHB-side bus bundle between the AHB master, the slave front end and the APB read path.
interface ahb_slave_interface_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned ADDR_WIDTH = 32;

  logic                  hwrite;
  logic                  hreadyin;
  logic [1:0]            htrans;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] haddr1;
  logic [ADDR_WIDTH-1:0] haddr2;
  logic [DATA_WIDTH-1:0] hwdata1;
  logic [DATA_WIDTH-1:0] hwdata2;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hwritereg;
  logic [2:0]            temp_selx;
  logic [1:0]            hresp;

  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata, prdata,
    input  valid, haddr1, haddr2, hwdata1, hwdata2, hrdata, hwritereg, temp_selx, hresp
  );

  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata, prdata,
    output valid, haddr1, haddr2, hwdata1, hwdata2, hrdata, hwritereg, temp_selx, hresp
  );
endinterface

// File: rtl/ahb_slave_interface.sv
// AHB front end of the AHB-to-APB bridge: transfer qualification, peripheral decode, pipelines.
// Optional macro AHB_SLV_ERRRESP_EN: returns a one-cycle ERROR response for out-of-range transfers.
module ahb_slave_interface #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                 hclk,
  input logic                 hresetn,
  ahb_slave_interface_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned SEL_WIDTH  = 3;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LO = 32'h8000_0000;
  localparam logic [ADDR_WIDTH-1:0] ADDR_HI = 32'h8C00_0000;

  logic                  active;
  logic                  in_range;
  logic [SEL_WIDTH-1:0]  sel;
  logic [ADDR_WIDTH-1:0] haddr1_q;
  logic [ADDR_WIDTH-1:0] haddr2_q;
  logic [DATA_WIDTH-1:0] hwdata1_q;
  logic [DATA_WIDTH-1:0] hwdata2_q;
  logic                  hwrite_q;

  // NONSEQ/SEQ with the bus ready; htrans[1] alone distinguishes them from IDLE/BUSY
  always_comb begin
    active   = bus.hreadyin & bus.htrans[1];
    in_range = (bus.haddr >= ADDR_LO) && (bus.haddr < ADDR_HI);
  end

  // 64 MB peripheral windows selected by haddr[31:26]
  always_comb begin
    sel = '0;
    unique case (bus.haddr[31:26])
      6'b100000: sel = 3'b001;
      6'b100001: sel = 3'b010;
      6'b100010: sel = 3'b100;
      default:   sel = 3'b000;
    endcase
  end

  // Free-running pipelines feeding the bridge FSM
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite_q  <= 1'b0;
    end else begin
      haddr1_q  <= bus.haddr;
      haddr2_q  <= haddr1_q;
      hwdata1_q <= bus.hwdata;
      hwdata2_q <= hwdata1_q;
      hwrite_q  <= bus.hwrite;
    end
  end

`ifdef AHB_SLV_ERRRESP_EN
  logic err_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= active & ~in_range;
    end
  end

  assign bus.hresp = {1'b0, err_q};
`else
  assign bus.hresp = 2'b00;
`endif

  assign bus.valid     = active & in_range;
  assign bus.temp_selx = sel;
  assign bus.hrdata    = bus.prdata;
  assign bus.haddr1    = haddr1_q;
  assign bus.haddr2    = haddr2_q;
  assign bus.hwdata1   = hwdata1_q;
  assign bus.hwdata2   = hwdata2_q;
  assign bus.hwritereg = hwrite_q;
endmodule

// File: tb/tb_ahb_slave_interface.sv
// Scoreboard bench for ahb_slave_interface: driver queues hand-computed expectations, monitor checks them.
module tb_ahb_slave_interface;
  localparam int unsigned DATA_WIDTH = 32;
`ifdef AHB_SLV_ERRRESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [2:0] M_COMB = 3'b001;
  localparam logic [2:0] M_P1   = 3'b010;
  localparam logic [2:0] M_P2   = 3'b100;
  localparam logic [2:0] M_ALL  = 3'b111;
  localparam logic [2:0] M_REGS = 3'b110;

  typedef struct {
    logic [2:0]  mask;
    logic        valid;
    logic [2:0]  sel;
    logic [31:0] hrdata;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic        wr1;
    logic [31:0] a2;
    logic [31:0] wd2;
    logic        err;
    int          id;
  } exp_t;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   vec_id = 0;
  exp_t sb[$];

  ahb_slave_interface_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  ahb_slave_interface #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus.slave)
  );

  always #5 hclk = ~hclk;

  function automatic exp_t mk(input logic [2:0] mask, input logic v, input logic [2:0] sel,
                              input logic [31:0] rd, input logic [31:0] a1, input logic [31:0] wd1,
                              input logic wr1, input logic [31:0] a2, input logic [31:0] wd2,
                              input logic err);
    exp_t e;
    e.mask = mask; e.valid = v; e.sel = sel; e.hrdata = rd;
    e.a1 = a1; e.wd1 = wd1; e.wr1 = wr1; e.a2 = a2; e.wd2 = wd2; e.err = err;
    e.id = 0;
    return e;
  endfunction

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0h expected %0h", id, name, act, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, queue what the monitor must see this cycle
  task automatic drive(input logic rstn, input logic wr, input logic rdy, input logic [1:0] tr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input exp_t e);
    exp_t q;
    @(posedge hclk);
    #1;
    hresetn      = rstn;
    bus.hwrite   = wr;
    bus.hreadyin = rdy;
    bus.htrans   = tr;
    bus.haddr    = a;
    bus.hwdata   = wd;
    bus.prdata   = rd;
    q    = e;
    q.id = vec_id;
    vec_id++;
    sb.push_back(q);
  endtask

  always @(negedge hclk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.mask[0]) begin
        cmp("valid", e.id, 32'(bus.valid), 32'(e.valid));
        cmp("temp_selx", e.id, 32'(bus.temp_selx), 32'(e.sel));
        cmp("hrdata", e.id, 32'(bus.hrdata), e.hrdata);
      end
      if (e.mask[1]) begin
        cmp("haddr1", e.id, bus.haddr1, e.a1);
        cmp("hwdata1", e.id, 32'(bus.hwdata1), e.wd1);
        cmp("hwritereg", e.id, 32'(bus.hwritereg), 32'(e.wr1));
      end
      if (e.mask[2]) begin
        cmp("haddr2", e.id, bus.haddr2, e.a2);
        cmp("hwdata2", e.id, 32'(bus.hwdata2), e.wd2);
      end
      cmp("hresp", e.id, 32'(bus.hresp), (e.err && ERR_EN) ? 32'd1 : 32'd0);
    end
  end

  initial begin
    bus.hwrite = 1'b0; bus.hreadyin = 1'b0; bus.htrans = 2'b00;
    bus.haddr = '0; bus.hwdata = '0; bus.prdata = '0;

    // Reset held with hwdata toggling
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_1000, 32'h526, 32'h0, mk(M_REGS, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_1000, 32'h0,   32'h0, mk(M_REGS, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Write NONSEQ; pipelines still hold reset values this cycle
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h8000_1000, 32'h526, 32'h624,
          mk(M_ALL, 1, 3'b001, 32'h624, 0, 0, 0, 0, 0, 0));
    // Not ready
    drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h8200_0000, 32'h664, 32'h522,
          mk(M_ALL, 0, 3'b001, 32'h522, 32'h8000_1000, 32'h526, 1, 0, 0, 0));
    // Decode sweep
    drive(1'b1, 1'b0, 1'b1, 2'b11, 32'h8400_0000, 32'h111, 32'hA5A5,
          mk(M_ALL, 1, 3'b010, 32'hA5A5, 32'h8200_0000, 32'h664, 0, 32'h8000_1000, 32'h526, 0));
    drive(1'b1, 1'b1, 1'b1, 2'b11, 32'h8BFF_FFFC, 32'h222, 32'h5A5A,
          mk(M_ALL, 1, 3'b100, 32'h5A5A, 32'h8400_0000, 32'h111, 0, 32'h8200_0000, 32'h664, 0));
    drive(1'b1, 1'b0, 1'b1, 2'b11, 32'h8C00_0000, 32'h333, 32'h1,
          mk(M_ALL, 0, 3'b000, 32'h1, 32'h8BFF_FFFC, 32'h222, 1, 32'h8400_0000, 32'h111, 0));
    drive(1'b1, 1'b0, 1'b1, 2'b11, 32'h7FFF_FFFC, 32'h444, 32'h2,
          mk(M_ALL, 0, 3'b000, 32'h2, 32'h8C00_0000, 32'h333, 0, 32'h8BFF_FFFC, 32'h222, 1));
    // IDLE then BUSY
    drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h8000_0000, 32'h555, 32'h3,
          mk(M_ALL, 0, 3'b001, 32'h3, 32'h7FFF_FFFC, 32'h444, 0, 32'h8C00_0000, 32'h333, 1));
    drive(1'b1, 1'b0, 1'b1, 2'b01, 32'h8000_0000, 32'h666, 32'h4,
          mk(M_ALL, 0, 3'b001, 32'h4, 32'h8000_0000, 32'h555, 0, 32'h7FFF_FFFC, 32'h444, 0));
    // Out-of-range NONSEQ, then in-range: ERROR lasts one cycle when enabled
    drive(1'b1, 1'b0, 1'b1, 2'b10, 32'h9000_0000, 32'h777, 32'h5,
          mk(M_ALL, 0, 3'b000, 32'h5, 32'h8000_0000, 32'h666, 0, 32'h8000_0000, 32'h555, 0));
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h8000_0004, 32'h888, 32'h6,
          mk(M_ALL, 1, 3'b001, 32'h6, 32'h9000_0000, 32'h777, 0, 32'h8000_0000, 32'h666, 1));
    drive(1'b1, 1'b0, 1'b1, 2'b11, 32'h8BFF_FFFF, 32'hAAA, 32'h7,
          mk(M_ALL, 1, 3'b100, 32'h7, 32'h8000_0004, 32'h888, 1, 32'h9000_0000, 32'h777, 0));
    drive(1'b1, 1'b0, 1'b1, 2'b10, 32'h7FFF_FFFF, 32'hBBB, 32'h8,
          mk(M_ALL, 0, 3'b000, 32'h8, 32'h8BFF_FFFF, 32'hAAA, 0, 32'h8000_0004, 32'h888, 0));
    // Reset asserted mid-transfer clears pipelines without waiting for an edge
    drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h8000_1000, 32'h999, 32'h9,
          mk(M_ALL, 1, 3'b001, 32'h9, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge hclk);
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
